// File: rtl/manch_decoder_pkg.sv
// Shared types and widths for the Manchester decoder.
// State encodings, default oversampling and byte sizing.
package manch_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int SPB_DEF = 8;
  localparam int BYTE_W  = 8;
  localparam int CNT_W   = 5;

endpackage

// File: rtl/manch_decoder_if.sv
// Line/lock inputs and byte/status outputs of the decoder.
// master drives the line, slave is the decoder.
interface manch_decoder_if;
  import manch_decoder_pkg::*;

  logic              data;
  logic              start;
  logic [BYTE_W-1:0] byte_out;
  logic              byte_valid;
  logic              frame_done;
  logic              code_err;
  logic              busy;
  logic [CNT_W-1:0]  byte_cnt;

  modport master (
    output data,
    output start,
    input  byte_out,
    input  byte_valid,
    input  frame_done,
    input  code_err,
    input  busy,
    input  byte_cnt
  );

  modport slave (
    input  data,
    input  start,
    output byte_out,
    output byte_valid,
    output frame_done,
    output code_err,
    output busy,
    output byte_cnt
  );

endinterface

// File: rtl/manch_decoder_slicer.sv
// Bit slicer: sample counter and half-bit latches.
// Strobes a bit or a violation on the last sample of each bit.
module manch_decoder_slicer
  import manch_decoder_pkg::*;
#(
  parameter int SPB = SPB_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic data,
  output logic bit_stb,
  output logic bit_val,
  output logic viol_stb
);

  localparam int SW = $clog2(SPB);
  localparam logic [SW-1:0] H1_AT = SW'(SPB / 4);
  localparam logic [SW-1:0] H2_AT = SW'(3 * SPB / 4);
  localparam logic [SW-1:0] LAST  = SW'(SPB - 1);

  logic [SW-1:0] scnt_q, scnt_d;
  logic          h1_q, h1_d;
  logic          h2_q, h2_d;
  logic          last;

  assign last = en && (scnt_q == LAST);

  always_comb begin
    scnt_d = '0;
    h1_d   = h1_q;
    h2_d   = h2_q;
    if (en && !last)
      scnt_d = scnt_q + SW'(1);
    if (en && scnt_q == H1_AT)
      h1_d = data;
    if (en && scnt_q == H2_AT)
      h2_d = data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scnt_q <= '0;
      h1_q   <= 1'b0;
      h2_q   <= 1'b0;
    end else begin
      scnt_q <= scnt_d;
      h1_q   <= h1_d;
      h2_q   <= h2_d;
    end
  end

  // high-then-low is a 1, so the first half is the bit
  assign bit_val  = h1_q;
  assign bit_stb  = last && (h1_q != h2_q);
  assign viol_stb = last && (h1_q == h2_q);

endmodule

// File: rtl/manch_decoder.sv
// Manchester frame decoder: FSM, byte packing, frame end.
// Bytes are MSB-first; a trailing violation ends the frame.
module manch_decoder
  import manch_decoder_pkg::*;
#(
  parameter int SPB       = SPB_DEF,
  parameter int SKIP      = 0,
  parameter int MAX_BYTES = 16
) (
  input logic           clk,
  input logic           rst,
  manch_decoder_if.slave bus
);

  localparam int SKW = (SKIP > 1) ? $clog2(SKIP) : 1;
  localparam logic [SKW-1:0] SK_LAST =
    SKW'((SKIP > 0) ? SKIP - 1 : 0);
  localparam logic [CNT_W-1:0] MAXB = CNT_W'(MAX_BYTES);

  state_e            state_q;
  logic              start_q;
  logic [SKW-1:0]    sk_q;
  logic [BYTE_W-2:0] sh_q;
  logic [2:0]        bcnt_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BYTE_W-1:0] byte_q;
  logic              bv_q;
  logic              fd_q;
  logic              ce_q;
  logic              busy_q;

  logic              bit_stb;
  logic              bit_val;
  logic              viol_stb;
  logic              arm_d;
  logic [BYTE_W-1:0] sh_d;
  logic [CNT_W-1:0]  cnt_d;

  manch_decoder_slicer #(
    .SPB (SPB)
  ) u_slicer (
    .clk      (clk),
    .rst      (rst),
    .en       (state_q == ST_RUN),
    .data     (bus.data),
    .bit_stb  (bit_stb),
    .bit_val  (bit_val),
    .viol_stb (viol_stb)
  );

  assign arm_d = bus.start && !start_q;
  assign sh_d  = {sh_q, bit_val};
  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      sk_q    <= '0;
      sh_q    <= '0;
      bcnt_q  <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      bv_q    <= 1'b0;
      fd_q    <= 1'b0;
      ce_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= bus.start;
      bv_q    <= 1'b0;
      fd_q    <= 1'b0;
      ce_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (arm_d) begin
            cnt_q   <= '0;
            bcnt_q  <= '0;
            sk_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= (SKIP > 0) ? ST_SKIP : ST_RUN;
          end
        end
        ST_SKIP: begin
          sk_q <= sk_q + SKW'(1);
          if (sk_q == SK_LAST)
            state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (bit_stb) begin
            sh_q   <= sh_d[BYTE_W-2:0];
            bcnt_q <= bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
              byte_q <= sh_d;
              bv_q   <= 1'b1;
              cnt_q  <= cnt_d;
              if (cnt_d == MAXB) begin
                fd_q    <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end
          end else if (viol_stb) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
            // clean end only on a byte boundary after data
            if (bcnt_q == 3'd0 && cnt_q != '0)
              fd_q <= 1'b1;
            else
              ce_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.byte_out   = byte_q;
  assign bus.byte_valid = bv_q;
  assign bus.frame_done = fd_q;
  assign bus.code_err   = ce_q;
  assign bus.busy       = busy_q;
  assign bus.byte_cnt   = cnt_q;

endmodule

// File: tb/tb_manch_decoder.sv
// Directed bench for manch_decoder.
// Two instances share the line: MAX_BYTES 16 and 2.
module tb_manch_decoder;
  import manch_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic sin = 1'b1;
  int total = 0;
  int bad = 0;
  int va = 0, fa = 0, ea = 0;
  int vb = 0, fb = 0, eb = 0;

  always #5 clk = ~clk;

  manch_decoder_if ia ();
  manch_decoder_if ib ();

  assign ia.data  = din;
  assign ia.start = sin;
  assign ib.data  = din;
  assign ib.start = sin;

  manch_decoder #(
    .SPB(8), .SKIP(0), .MAX_BYTES(16)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ia.slave)
  );

  manch_decoder #(
    .SPB(8), .SKIP(0), .MAX_BYTES(2)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ib.slave)
  );

  always @(negedge clk) begin
    if (ia.byte_valid) va++;
    if (ia.frame_done) fa++;
    if (ia.code_err)   ea++;
    if (ib.byte_valid) vb++;
    if (ib.frame_done) fb++;
    if (ib.code_err)   eb++;
  end

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp(logic b);
    din = b;
    tick();
  endtask

  task automatic sbit(logic b);
    for (int i = 0; i < 4; i++) samp(b);
    for (int i = 0; i < 4; i++) samp(~b);
  endtask

  task automatic sbyte(logic [7:0] v);
    for (int i = 7; i >= 0; i--) sbit(v[i]);
  endtask

  task automatic idle8(logic b);
    for (int i = 0; i < 8; i++) samp(b);
  endtask

  task automatic arm();
    sin = 1'b0;
    tick();
    sin = 1'b1;
    tick();
  endtask

  initial begin
    // 1: reset with start high
    repeat (3) tick();
    chk("rst_out", 32'(ia.byte_out), 0);
    chk("rst_flags", 32'({ia.byte_valid,
        ia.frame_done, ia.code_err,
        ia.busy}), 0);
    chk("rst_cnt", 32'(ia.byte_cnt), 0);
    rst = 1'b0;
    tick();
    chk("rel_busy_a", 32'(ia.busy), 1);
    chk("rel_busy_b", 32'(ib.busy), 1);

    // 2: 0xA5, 0x3C, then low
    sbyte(8'hA5);
    chk("t2_bv0", 32'(ia.byte_valid), 1);
    chk("t2_b0", 32'(ia.byte_out), 32'hA5);
    chk("t2_c0", 32'(ia.byte_cnt), 1);
    sbyte(8'h3C);
    chk("t2_b1", 32'(ia.byte_out), 32'h3C);
    chk("t2_busy1", 32'(ia.busy), 1);
    chk("t2_fd_b", 32'(ib.frame_done), 1);
    chk("t2_bv_b", 32'(ib.byte_valid), 1);
    chk("t2_busy_b", 32'(ib.busy), 0);
    idle8(1'b0);
    chk("t2_fd", 32'(ia.frame_done), 1);
    chk("t2_ce", 32'(ia.code_err), 0);
    chk("t2_busy", 32'(ia.busy), 0);
    chk("t2_cnt", 32'(ia.byte_cnt), 2);

    // 3: three bits then a high violation
    arm();
    chk("t3_busy", 32'(ia.busy), 1);
    sbit(1'b1);
    sbit(1'b0);
    sbit(1'b1);
    idle8(1'b1);
    chk("t3_ce", 32'(ia.code_err), 1);
    chk("t3_fd", 32'(ia.frame_done), 0);
    chk("t3_busy0", 32'(ia.busy), 0);
    chk("t3_cnt", 32'(ia.byte_cnt), 0);
    chk("t3_keep", 32'(ia.byte_out), 32'h3C);
    chk("t3_ce_b", 32'(ib.code_err), 1);

    // 4: byte limit on dut_b
    arm();
    chk("t4_va", 32'(va), 2);
    chk("t4_fa", 32'(fa), 1);
    chk("t4_ea", 32'(ea), 1);
    sbyte(8'h11);
    sbyte(8'h22);
    chk("t4_bv_b", 32'(ib.byte_valid), 1);
    chk("t4_fd_b", 32'(ib.frame_done), 1);
    chk("t4_busy_b", 32'(ib.busy), 0);
    chk("t4_cnt_b", 32'(ib.byte_cnt), 2);
    chk("t4_busy_a", 32'(ia.busy), 1);
    sbyte(8'h33);
    chk("t4_b_a", 32'(ia.byte_out), 32'h33);
    chk("t4_keep_b", 32'(ib.byte_out), 32'h22);
    idle8(1'b0);
    chk("t4_fd_a", 32'(ia.frame_done), 1);
    chk("t4_cnt_a", 32'(ia.byte_cnt), 3);
    tick();
    chk("t4_vb", 32'(vb), 4);
    chk("t4_fb", 32'(fb), 2);

    // 5: start held high, then re-armed
    sbyte(8'h55);
    idle8(1'b0);
    tick();
    chk("t5_busy", 32'(ia.busy), 0);
    chk("t5_va", 32'(va), 5);
    chk("t5_fa", 32'(fa), 2);
    chk("t5_ea", 32'(ea), 1);
    chk("t5_cnt", 32'(ia.byte_cnt), 3);
    arm();
    chk("t5_arm", 32'(ia.busy), 1);
    sbyte(8'h96);
    chk("t5_b", 32'(ia.byte_out), 32'h96);
    chk("t5_c", 32'(ia.byte_cnt), 1);
    chk("t5_fd_b0", 32'(ib.frame_done), 0);
    idle8(1'b0);
    chk("t5_fd", 32'(ia.frame_done), 1);
    chk("t5_fd_b", 32'(ib.frame_done), 1);

    // 6: reset mid-byte
    arm();
    sbit(1'b1);
    sbit(1'b0);
    sbit(1'b1);
    sbit(1'b1);
    rst = 1'b1;
    sin = 1'b0;
    tick();
    chk("t6_out", 32'(ia.byte_out), 0);
    chk("t6_flags", 32'({ia.byte_valid,
        ia.frame_done, ia.code_err,
        ia.busy}), 0);
    chk("t6_cnt", 32'(ia.byte_cnt), 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++)
      samp(1'(i % 2));
    tick();
    chk("t6_va", 32'(va), 6);
    chk("t6_fa", 32'(fa), 3);
    chk("t6_ea", 32'(ea), 1);
    chk("t6_vb", 32'(vb), 5);
    chk("t6_eb", 32'(eb), 1);
    arm();
    sbyte(8'hFF);
    chk("t6_ff", 32'(ia.byte_out), 32'hFF);
    chk("t6_bv", 32'(ia.byte_valid), 1);
    idle8(1'b0);
    chk("t6_fd", 32'(ia.frame_done), 1);
    chk("t6_c", 32'(ia.byte_cnt), 1);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
